sram_pixel_reader: RTL

- Pixel-side read engine for the shared DMA/pixel line SRAM. The DMA writer fills this SRAM through the memory controller; this block is the matching reader.
- Requests the clock switch to the pixel clock and waits for it to settle. Then issues sequential reads of LEN words from BASE and streams them out on a valid/ready pixel interface.
- Absorbs the SRAM's 1-cycle read latency with a 2-entry output buffer. Signals completion so the memory controller can release the clock.

---
 rtl/sram_pixel_reader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sram_pixel_reader.sv
// Pixel-side reader for the shared line SRAM: requests the pixel clock, streams LEN words
// from BASE through a 2-entry buffer onto a valid/ready port, then releases the clock.
module sram_pixel_reader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 9,
    parameter int SWITCH_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pixel_trigger_o,
    output logic              pixel_trigger_done_o,
    output logic              rd_o,
    output logic [ADDR_W-1:0] addr_rd_o,
    input  logic [DATA_W-1:0] sram_data_i,
    output logic [DATA_W-1:0] pix_data_o,
    output logic              pix_valid_o,
    input  logic              pix_ready_i,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SWITCH = 3'd1,
        S_READ   = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0]     SW_LAST = 4'(SWITCH_CYC - 1);
    localparam logic [ADDR_W:0] ONE    = 1;

    state_t              state_q, state_d;
    logic [3:0]          wait_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     len_q, issued_q, accepted_q;
    logic                inflight_q;
    logic                zero_done_q;
    logic [1:0]          count_q;
    logic                wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0]   fifo_q [2];

    logic                push, pop;
    logic [2:0]          slots;
    logic                last_issue, last_accept;

    // Pixel port: a word moves when pix_valid_o & pix_ready_i at a rising edge; once valid
    // is raised, data and valid hold until that transfer happens.
    assign pix_valid_o = (count_q != 2'd0);
    assign pix_data_o  = fifo_q[rd_ptr_q];
    assign pop         = pix_valid_o & pix_ready_i;
    assign push        = inflight_q;

    // Buffer slots already committed (stored plus in flight), net of this cycle's pop.
    assign slots       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign last_issue  = rd_o && ((issued_q + ONE) == len_q);
    assign last_accept = pop && ((accepted_q + ONE) == len_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start_i && len_i != '0) state_d = S_SWITCH;
            S_SWITCH: if (wait_q == SW_LAST)      state_d = S_READ;
            S_READ:   if (last_issue)             state_d = S_DRAIN;
            S_DRAIN:  if (last_accept)            state_d = S_DONE;
            S_DONE:                               state_d = S_IDLE;
            default:                              state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o               = (state_q != S_IDLE);
        pixel_trigger_o      = (state_q == S_SWITCH) && (wait_q == 4'd0);
        pixel_trigger_done_o = (state_q == S_DONE);
        done_o               = (state_q == S_DONE) || zero_done_q;
        rd_o                 = (state_q == S_READ) && (issued_q != len_q) && (slots < 3'd2);
        addr_rd_o            = rd_o ? (base_q + issued_q[ADDR_W-1:0]) : addr_q;
        state_dbg            = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q      <= '0;
            base_q      <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            accepted_q  <= '0;
            inflight_q  <= 1'b0;
            zero_done_q <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
        end else begin
            zero_done_q <= (state_q == S_IDLE) && start_i && (len_i == '0);
            wait_q      <= (state_q == S_SWITCH) ? wait_q + 4'd1 : 4'd0;
            inflight_q  <= rd_o;
            if (state_q == S_IDLE && start_i) begin
                base_q     <= base_addr_i;
                len_q      <= len_i;
                issued_q   <= '0;
                accepted_q <= '0;
            end
            if (rd_o) begin
                issued_q <= issued_q + ONE;
                addr_q   <= addr_rd_o;
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= sram_data_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q   <= ~rd_ptr_q;
                accepted_q <= accepted_q + ONE;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
